// File: rtl/spi_reg_bridge_if.sv
// rtl/spi_reg_bridge_if.sv - register-bus bundle between the SPI bridge and the GPIO register block
interface spi_reg_bridge_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_we;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_addr,
    output bus_wdata,
    output bus_we,
    input  bus_rdata
  );

  modport slave (
    input  bus_addr,
    input  bus_wdata,
    input  bus_we,
    output bus_rdata
  );
endinterface

// File: rtl/spi_reg_bridge.sv
// rtl/spi_reg_bridge.sv - SPI mode-0 slave turning 16-bit frames into register-bus writes/reads
// Read frames return data on miso only when SPI_BRIDGE_READBACK_EN is defined.
module spi_reg_bridge #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  spi_reg_bridge_if.master bus,
  output logic             busy,
  output logic             frame_err
);

  typedef enum logic [2:0] {IDLE, CMD, DATA, COMMIT, DRAIN} state_t;

  state_t     state;
  logic [4:0] bit_cnt;
  logic [7:0] rx;
  logic       is_wr;

  logic [1:0] sclk_sync, cs_sync, mosi_sync;
  logic       sclk_d, cs_d;
  logic       sclk_rise, sclk_fall, cs_fall, cs_high, mosi_s;

  // cs flops reset low so a chip select already low at reset release never
  // looks like a falling edge; a frame can start only after cs_n is seen high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= 2'b00;
      cs_sync   <= 2'b00;
      mosi_sync <= 2'b00;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      cs_sync   <= {cs_sync[0], cs_n};
      mosi_sync <= {mosi_sync[0], mosi};
      sclk_d    <= sclk_sync[1];
      cs_d      <= cs_sync[1];
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_d;
  assign sclk_fall = ~sclk_sync[1] & sclk_d;
  assign cs_fall   = ~cs_sync[1] & cs_d;
  assign cs_high   = cs_sync[1];
  assign mosi_s    = mosi_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bit_cnt       <= 5'd0;
      rx            <= 8'd0;
      is_wr         <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      bus.bus_we    <= 1'b0;
      busy          <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      bus.bus_we <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state     <= CMD;
            bit_cnt   <= 5'd0;
            frame_err <= 1'b0;
            busy      <= 1'b1;
          end
        end
        CMD: begin
          if (cs_high) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (bit_cnt != 5'd0) frame_err <= 1'b1;
          end else if (sclk_rise) begin
            rx      <= {rx[6:0], mosi_s};
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd0) is_wr <= mosi_s;
            if (bit_cnt == 5'd7) begin
              bus.bus_addr <= ADDR_W'({rx[6:0], mosi_s});
              state        <= DATA;
            end
          end
        end
        DATA: begin
          if (cs_high) begin
            state     <= IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b1;
          end else if (sclk_rise) begin
            rx      <= {rx[6:0], mosi_s};
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd15) state <= is_wr ? COMMIT : DRAIN;
          end
        end
        COMMIT: begin
          bus.bus_we    <= 1'b1;
          bus.bus_wdata <= DATA_W'(rx);
          state         <= DRAIN;
        end
        DRAIN: begin
          if (cs_high) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_BRIDGE_READBACK_EN
  logic              rd_load;
  logic [DATA_W-1:0] tx_sr;
  logic              miso_q;

  // rd_load trails the address load by one cycle so bus_rdata reflects the new address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_load <= 1'b0;
      tx_sr   <= '0;
      miso_q  <= 1'b0;
    end else begin
      rd_load <= (state == CMD) && !cs_high && sclk_rise && (bit_cnt == 5'd7) && !is_wr;
      if (rd_load) tx_sr <= bus.bus_rdata;
      if (state == IDLE) begin
        miso_q <= 1'b0;
      end else if (sclk_fall) begin
        if (state == DATA && !is_wr) begin
          miso_q <= tx_sr[DATA_W-1];
          tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
        end else begin
          miso_q <= 1'b0;
        end
      end
    end
  end

  assign miso = miso_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^bus.bus_rdata;
  assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb/tb_spi_reg_bridge.sv - self-checking bench for spi_reg_bridge with a frame-level schedule model
module tb_spi_reg_bridge;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;
  logic miso, busy, frame_err;
  logic [7:0] rdata_drv = 8'h00;

  spi_reg_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();
  assign bif.bus_rdata = rdata_drv;

  spi_reg_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .bus       (bif),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit rb_en = 1'b0;
  bit armed = 1'b0;
  int we_pulses = 0;
  int last_we_cyc = 0;
  int last_r16 = 0;
  logic [7:0] rx_cap = 8'h00;

  // Expected output changes keyed by the clk cycle in which they become visible.
  logic [3:0] addr_s[int];
  logic [7:0] wdata_s[int];
  bit         we_s[int];
  bit         busy_s[int];
  bit         err_s[int];
  bit         miso_s[int];

  logic [3:0] exp_addr = 4'h0;
  logic [7:0] exp_wdata = 8'h00;
  logic       exp_we = 1'b0;
  logic       exp_busy = 1'b0;
  logic       exp_err = 1'b0;
  logic       exp_miso = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial forever begin
    @(negedge clk);
    if (bif.bus_we === 1'b1) begin
      we_pulses++;
      last_we_cyc = cyc;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      exp_addr  = 4'h0;
      exp_wdata = 8'h00;
      exp_busy  = 1'b0;
      exp_err   = 1'b0;
      exp_miso  = 1'b0;
      exp_we    = 1'b0;
    end else begin
      if (addr_s.exists(cyc))  exp_addr  = addr_s[cyc];
      if (wdata_s.exists(cyc)) exp_wdata = wdata_s[cyc];
      if (busy_s.exists(cyc))  exp_busy  = busy_s[cyc];
      if (err_s.exists(cyc))   exp_err   = err_s[cyc];
      if (miso_s.exists(cyc))  exp_miso  = miso_s[cyc];
      exp_we = we_s.exists(cyc);
    end
    check("bus_we",    32'(bif.bus_we),    32'(exp_we));
    check("bus_addr",  32'(bif.bus_addr),  32'(exp_addr));
    check("bus_wdata", 32'(bif.bus_wdata), 32'(exp_wdata));
    check("busy",      32'(busy),          32'(exp_busy));
    check("frame_err", 32'(frame_err),     32'(exp_err));
    check("miso",      32'(miso),          32'(exp_miso));
  end

  // bits[19] is the first bit on the wire; rst_after pulses rst_n after that bit's fall.
  task automatic frame(input logic [19:0] bits, input int nbits, input int rst_after,
                       input logic [7:0] rd);
    logic [15:0] frm;
    bit w, live;
    int c, r, n;
    frm = bits[19:4];
    w = frm[15];
    rdata_drv = rd;
    rx_cap = 8'h00;
    live = armed;
    cs_n = 1'b0;
    c = cyc;
    if (live) begin
      busy_s[c+3] = 1'b1;
      err_s[c+3]  = 1'b0;
    end
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      n = i + 1;
      mosi = bits[19-i];
      tick(2);
      sclk = 1'b1;
      r = cyc;
      if (n >= 9 && n <= 16) rx_cap = {rx_cap[6:0], miso};
      if (live && n == 8) addr_s[r+3] = frm[11:8];
      if (live && n == 16) begin
        last_r16 = r;
        if (w) begin
          we_s[r+4]    = 1'b1;
          wdata_s[r+4] = frm[7:0];
        end
      end
      tick(5);
      sclk = 1'b0;
      if (live) miso_s[cyc+3] = (rb_en && !w && n >= 8 && n <= 15) ? rd[15-n] : 1'b0;
      tick(3);
      if (n == rst_after) begin
        rst_n = 1'b0;
        addr_s.delete();
        wdata_s.delete();
        we_s.delete();
        busy_s.delete();
        err_s.delete();
        miso_s.delete();
        live = 1'b0;
        armed = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
      end
    end
    cs_n = 1'b1;
    c = cyc;
    if (live) begin
      busy_s[c+3] = 1'b0;
      miso_s[c+4] = 1'b0;
      if (nbits >= 1 && nbits <= 15) err_s[c+3] = 1'b1;
    end
    tick(6);
    armed = 1'b1;
  endtask

  initial begin
`ifdef SPI_BRIDGE_READBACK_EN
    rb_en = 1'b1;
`endif
    tick(3);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_bus_addr",  32'(bif.bus_addr), 32'd0);
    check("rst_miso",      32'(miso),      32'd0);
    rst_n = 1'b1;
    tick(5);
    armed = 1'b1;

    frame({16'h83A5, 4'h0}, 16, -1, 8'h00);
    check("w1_pulses",   32'(we_pulses), 32'd1);
    check("w1_latency",  32'(last_we_cyc - last_r16), 32'd4);
    check("w1_addr",     32'(bif.bus_addr), 32'h3);
    check("w1_wdata",    32'(bif.bus_wdata), 32'hA5);
    check("w1_frame_err", 32'(frame_err), 32'd0);

    frame({16'h0700, 4'h0}, 16, -1, 8'h5C);
    check("r1_miso_bits", 32'(rx_cap), rb_en ? 32'h5C : 32'h00);
    check("r1_pulses",   32'(we_pulses), 32'd1);
    check("r1_addr",     32'(bif.bus_addr), 32'h7);

    frame({16'h8C33, 4'h0}, 9, -1, 8'h00);
    check("abort_frame_err", 32'(frame_err), 32'd1);
    check("abort_pulses",    32'(we_pulses), 32'd1);

    frame({16'h8B69, 4'h0}, 16, -1, 8'h00);
    check("w2_frame_err", 32'(frame_err), 32'd0);
    check("w2_pulses",    32'(we_pulses), 32'd2);
    check("w2_wdata",     32'(bif.bus_wdata), 32'h69);

    frame({16'h82FF, 4'hA}, 20, -1, 8'h00);
    check("long_pulses",    32'(we_pulses), 32'd3);
    check("long_addr",      32'(bif.bus_addr), 32'h2);
    check("long_wdata",     32'(bif.bus_wdata), 32'hFF);
    check("long_frame_err", 32'(frame_err), 32'd0);

    frame({16'h8E77, 4'h0}, 16, 10, 8'h00);
    check("rst_mid_addr",   32'(bif.bus_addr), 32'h0);
    check("rst_mid_wdata",  32'(bif.bus_wdata), 32'h00);
    check("rst_mid_err",    32'(frame_err), 32'd0);
    check("rst_mid_busy",   32'(busy), 32'd0);
    check("rst_mid_pulses", 32'(we_pulses), 32'd3);

    frame({16'h8D12, 4'h0}, 16, -1, 8'h00);
    check("w3_pulses",  32'(we_pulses), 32'd4);
    check("w3_addr",    32'(bif.bus_addr), 32'hD);
    check("w3_wdata",   32'(bif.bus_wdata), 32'h12);
    check("w3_latency", 32'(last_we_cyc - last_r16), 32'd4);

    frame({16'h0100, 4'h0}, 16, -1, 8'hA3);
    check("r2_miso_bits", 32'(rx_cap), rb_en ? 32'hA3 : 32'h00);
    check("r2_pulses",    32'(we_pulses), 32'd4);
    check("r2_addr",      32'(bif.bus_addr), 32'h1);

    frame({16'h0000, 4'h0}, 0, -1, 8'h00);
    check("empty_frame_err", 32'(frame_err), 32'd0);
    check("empty_pulses",    32'(we_pulses), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", miscompares);
    $fatal(1);
  end

endmodule
